univ_register: RTL

Parametrised universal register: the next-generation successor to the team's plain load/enable register. It adds synchronous clear, an 8-mode operation field (shift, rotate, arithmetic shift, increment and decrement), a serial port and sticky overflow reporting. It is used as the general-purpose datapath register for shifters, serialisers and loop counters in the control path. Counting can be configured to wrap or to saturate.

---
 rtl/univ_register.sv | 122 ++++++++++++
 1 files changed

// File: rtl/univ_register.sv
// univ_register: general-purpose datapath register with parallel load,
// synchronous clear, shift/rotate/arithmetic-shift, inc/dec counting
// (wrap or saturate) and a sticky overflow flag.
module univ_register #(
  parameter int WIDTH     = 8,
  parameter bit COUNT_SAT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_s,
  input  logic             ld_s,
  input  logic             en_s,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] inp,
  input  logic             ser_in,
  output logic [WIDTH-1:0] oup,
  output logic             ser_out,
  output logic             ovf,
  output logic             zero
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHL  = 3'b001,
    MODE_SHR  = 3'b010,
    MODE_ROL  = 3'b011,
    MODE_ROR  = 3'b100,
    MODE_INC  = 3'b101,
    MODE_DEC  = 3'b110,
    MODE_ASHR = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_oup;
  logic             r_ser_out;
  logic             r_ovf;

  logic [WIDTH-1:0] w_oup_next;
  logic             w_ser_out_next;
  logic             w_ovf_next;
  logic             w_all_ones;
  logic             w_all_zero;

  assign w_all_ones = &r_oup;
  assign w_all_zero = ~|r_oup;

  // Next-state selection in priority order clr > ld > en(mode) > hold
  always_comb begin
    w_oup_next     = r_oup;
    w_ser_out_next = r_ser_out;
    w_ovf_next     = r_ovf;
    if (clr_s) begin
      w_oup_next     = '0;
      w_ser_out_next = 1'b0;
      w_ovf_next     = 1'b0;
    end else if (ld_s) begin
      w_oup_next = inp;
      w_ovf_next = 1'b0;
    end else if (en_s) begin
      case (mode_e'(mode))
        MODE_HOLD: ;
        MODE_SHL: begin
          w_oup_next     = {r_oup[WIDTH-2:0], ser_in};
          w_ser_out_next = r_oup[WIDTH-1];
        end
        MODE_SHR: begin
          w_oup_next     = {ser_in, r_oup[WIDTH-1:1]};
          w_ser_out_next = r_oup[0];
        end
        MODE_ROL: begin
          w_oup_next     = {r_oup[WIDTH-2:0], r_oup[WIDTH-1]};
          w_ser_out_next = r_oup[WIDTH-1];
        end
        MODE_ROR: begin
          w_oup_next     = {r_oup[0], r_oup[WIDTH-1:1]};
          w_ser_out_next = r_oup[0];
        end
        MODE_INC: begin
          // Boundary: all-ones either wraps to zero or sticks, and flags ovf
          if (w_all_ones) begin
            w_ovf_next = 1'b1;
            w_oup_next = COUNT_SAT ? r_oup : '0;
          end else begin
            w_oup_next = r_oup + WIDTH'(1);
          end
        end
        MODE_DEC: begin
          // Boundary: zero either wraps to all-ones or sticks, and flags ovf
          if (w_all_zero) begin
            w_ovf_next = 1'b1;
            w_oup_next = COUNT_SAT ? r_oup : '1;
          end else begin
            w_oup_next = r_oup - WIDTH'(1);
          end
        end
        MODE_ASHR: begin
          w_oup_next     = {r_oup[WIDTH-1], r_oup[WIDTH-1:1]};
          w_ser_out_next = r_oup[0];
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_oup     <= '0;
      r_ser_out <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_oup     <= w_oup_next;
      r_ser_out <= w_ser_out_next;
      r_ovf     <= w_ovf_next;
    end
  end

  assign oup     = r_oup;
  assign ser_out = r_ser_out;
  assign ovf     = r_ovf;
  assign zero    = w_all_zero;

endmodule
